// File: rtl/prng_pkg.sv
// Shared definitions for the xorshift pseudo-random generator:
// FSM state encoding, default shift triple, default seed and shift directions.
package prng_pkg;

  // Generator sequencing: idle, then one shift-XOR stage per cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } fsm_e;

  // Default shift triple (x ^= x<<7; x ^= x>>9; x ^= x<<8)
  localparam int PRNG_SA = 7;
  localparam int PRNG_SB = 9;
  localparam int PRNG_SC = 8;

  // Reset state and replacement for a zero seed when the guard is built in
  localparam logic [15:0] PRNG_DEFAULT_SEED = 16'hACE1;

  // Shift direction selector for xs_stage
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/xs_stage.sv
// One combinational xorshift stage: o_x = i_x ^ (i_x shifted by AMT),
// logical shift, truncated to WIDTH bits. DIR selects left or right.
module xs_stage
  import prng_pkg::*;
#(
  parameter int   WIDTH = 16,
  parameter int   AMT   = 1,
  parameter logic DIR   = DIR_LEFT
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_x
);

  generate
    if (DIR == DIR_RIGHT) begin : g_right
      assign o_x = i_x ^ (i_x >> AMT);
    end else begin : g_left
      assign o_x = i_x ^ (i_x << AMT);
    end
  endgenerate

endmodule

// File: rtl/xorshift_prng.sv
// Parametrised xorshift PRNG. One shift-XOR stage is applied per cycle
// (S1, S2, S3); the word is published on S3 over a valid/ready handshake.
// seed_load overrides everything and restarts the generator from `seed`.
// Build option: PRNG_ZERO_GUARD_EN -- when defined, a zero seed is replaced
// by DEFAULT_SEED so the generator can never lock up at zero.
module xorshift_prng
  import prng_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               SA           = PRNG_SA,
  parameter int               SB           = PRNG_SB,
  parameter int               SC           = PRNG_SC,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(PRNG_DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gen_count
);

  fsm_e             r_fsm;
  logic [WIDTH-1:0] r_x;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_gen_count;

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] w_s3;
  logic [WIDTH-1:0] w_x_next;
  logic [WIDTH-1:0] w_seed_eff;
  logic             w_req_fire;

  // All three stages see the current state; the FSM picks which one applies
  xs_stage #(.WIDTH(WIDTH), .AMT(SA), .DIR(DIR_LEFT))  u_stage_a (.i_x(r_x), .o_x(w_s1));
  xs_stage #(.WIDTH(WIDTH), .AMT(SB), .DIR(DIR_RIGHT)) u_stage_b (.i_x(r_x), .o_x(w_s2));
  xs_stage #(.WIDTH(WIDTH), .AMT(SC), .DIR(DIR_LEFT))  u_stage_c (.i_x(r_x), .o_x(w_s3));

`ifdef PRNG_ZERO_GUARD_EN
  assign w_seed_eff = (seed == {WIDTH{1'b0}}) ? DEFAULT_SEED : seed;
`else
  assign w_seed_eff = seed;
`endif

  // A request is taken only when idle, the output slot is free (or being
  // freed this cycle) and no reseed is happening
  assign req_ready  = (r_fsm == IDLE) && (!r_out_valid || out_ready) && !seed_load;
  assign w_req_fire = req_ready && req_valid;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign gen_count = r_gen_count;

  // Select the stage result for the current FSM step; hold the state when idle
  always_comb begin
    w_x_next = r_x;
    case (r_fsm)
      S1:      w_x_next = w_s1;
      S2:      w_x_next = w_s2;
      S3:      w_x_next = w_s3;
      default: w_x_next = r_x;
    endcase
  end

  // FSM sequencing; a reseed aborts any computation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else if (seed_load) begin
      r_fsm <= IDLE;
    end else begin
      case (r_fsm)
        IDLE:    r_fsm <= w_req_fire ? S1 : IDLE;
        S1:      r_fsm <= S2;
        S2:      r_fsm <= S3;
        S3:      r_fsm <= IDLE;
        default: r_fsm <= IDLE;
      endcase
    end
  end

  // Generator state: reseed or advance by one stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= DEFAULT_SEED;
    end else if (seed_load) begin
      r_x <= w_seed_eff;
    end else begin
      r_x <= w_x_next;
    end
  end

  // Output register: publish on S3, otherwise hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
    end else if (seed_load) begin
      r_out_valid <= 1'b0;
    end else if (r_fsm == S3) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_s3;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Count of words produced since reset or the last reseed, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen_count <= {WIDTH{1'b0}};
    end else if (seed_load) begin
      r_gen_count <= {WIDTH{1'b0}};
    end else if (r_fsm == S3) begin
      r_gen_count <= r_gen_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_gen_count <= r_gen_count;
    end
  end

endmodule

// File: tb/tb_xorshift_prng.sv
// Self-checking bench for xorshift_prng (default parameters).
// A transaction-level model (countdown to completion, full xorshift applied
// at once) is compared against the DUT on every falling clock edge, and
// directed scenarios add literal expectations.
module tb_xorshift_prng;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed      = 16'h0000;
  logic        req_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        req_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] gen_count;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  xorshift_prng dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  // Full xorshift step straight from the arithmetic definition
  function automatic logic [15:0] xs_ref(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    t = t ^ (t << 7);
    t = t ^ (t >> 9);
    t = t ^ (t << 8);
    return t;
  endfunction

  function automatic logic [15:0] seed_value(input logic [15:0] s);
`ifdef PRNG_ZERO_GUARD_EN
    return (s == 16'h0000) ? 16'hACE1 : s;
`else
    return s;
`endif
  endfunction

  typedef struct {
    logic [15:0] x;
    int          busy;   // cycles until the pending word appears (0 = none)
    logic        valid;
    logic [15:0] data;
    logic [15:0] count;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.x = 16'hACE1; r.busy = 0; r.valid = 1'b0; r.data = 16'h0000; r.count = 16'h0000;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input logic sl, input logic [15:0] sd,
                                       input logic rv, input logic ordy);
    model_t n;
    logic   ready;
    n = c;
    ready = (c.busy == 0) && (!c.valid || ordy) && !sl;
    if (sl) begin
      n.x = seed_value(sd); n.busy = 0; n.valid = 1'b0; n.count = 16'h0000;
    end else begin
      if (c.valid && ordy) n.valid = 1'b0;
      if (c.busy == 1) begin
        n.x = xs_ref(c.x); n.data = n.x; n.valid = 1'b1;
        n.count = c.count + 16'd1; n.busy = 0;
      end else if (c.busy > 1) begin
        n.busy = c.busy - 1;
      end else if (ready && rv) begin
        n.busy = 3;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, seed_load, seed, req_valid, out_ready);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m.valid));
      check("cyc_out_data",  32'(out_data),  32'(m.data));
      check("cyc_gen_count", 32'(gen_count), 32'(m.count));
      check("cyc_req_ready", 32'(req_ready),
            32'((m.busy == 0) && (!m.valid || out_ready) && !seed_load));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_seed(input logic [15:0] v);
    seed_load = 1'b1;
    seed      = v;
    step();
    seed_load = 1'b0;
  endtask

  task automatic request();
    bit ok;
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = req_ready;
      step();
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("req_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_word(input string name, input logic [15:0] exp_data, input logic [15:0] exp_cnt);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"},  32'(out_data),  32'(exp_data));
    check({name, "_count"}, 32'(gen_count), 32'(exp_cnt));
    step();
  endtask

  initial begin
    logic [15:0] e;

    // Pin the reference function with hand-computed values
    check("pin_xs_0001", 32'(xs_ref(16'h0001)), 32'h8181);
    check("pin_xs_8181", 32'(xs_ref(16'h8181)), 32'h6021);
    check("pin_xs_0000", 32'(xs_ref(16'h0000)), 32'h0000);

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    cmp_en = 1'b1;
    #19 rst_n = 1'b1;
    step();

    // Reset asserted mid-S2 is immediate
    out_ready = 1'b1;
    request();
    step();
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data",  32'(out_data),  32'd0);
    check("async_gen_count", 32'(gen_count), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd1);
    #1 rst_n = 1'b1;
    step();
    request();
    wait_word("after_reset", xs_ref(16'hACE1), 16'd1);

    // Seed 1: two words
    do_seed(16'h0001);
    request();
    wait_word("seed1_w1", 16'h8181, 16'd1);
    request();
    wait_word("seed1_w2", 16'h6021, 16'd2);

    // Backpressure
    do_seed(16'h0001);
    out_ready = 1'b0;
    request();
    wait_word("bp_w1", 16'h8181, 16'd1);
    req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_refused", 32'(req_ready), 32'd0);
      check("bp_hold",    32'(out_data),  32'h8181);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_same_edge", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_consumed", 32'(out_valid), 32'd0);
    step();
    wait_word("bp_w2", 16'h6021, 16'd2);

    // Reseed during S2 aborts the computation
    do_seed(16'h0001);
    request();
    step();
    do_seed(16'h1234);
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_gen_count", 32'(gen_count), 32'd0);
    check("abort_idle",      32'(req_ready), 32'd1);
    step();
    request();
    wait_word("abort_next", xs_ref(16'h1234), 16'd1);

    // seed_load together with req_valid
    seed_load = 1'b1;
    seed      = 16'h0001;
    req_valid = 1'b1;
    @(negedge clk);
    check("sl_rv_ready", 32'(req_ready), 32'd0);
    step();
    seed_load = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("sl_rv_not_started", 32'(req_ready), 32'd1);
    step();
    request();
    wait_word("sl_rv_word", 16'h8181, 16'd1);

    // Zero seed
    do_seed(16'h0000);
`ifdef PRNG_ZERO_GUARD_EN
    e = 16'hACE1;
`else
    e = 16'h0000;
`endif
    for (int i = 0; i < 3; i++) begin
      e = xs_ref(e);
      request();
      wait_word("zero_seed", e, 16'(i + 1));
    end

    // Randomised traffic checked by the per-cycle comparison
    for (int i = 0; i < 400; i++) begin
      seed_load = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      req_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    seed_load = 1'b0;
    req_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
